// File: rtl/stopwatch_pkg.sv
// Shared types, BCD limits and the BCD digit-pair increment used by the stopwatch.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        FULL  = 2'd3
    } sw_state_e;

    localparam logic [7:0] CS_MAX  = 8'h99;
    localparam logic [7:0] SEC_MAX = 8'h59;
    localparam logic [7:0] MIN_MAX = 8'h59;

    typedef struct packed {
        logic       carry;
        logic [7:0] val;
    } bcd_inc_t;

    // Two-digit BCD increment; wraps to 00 with carry once the pair reaches lim.
    function automatic bcd_inc_t bcd_inc(input logic [7:0] v, input logic [7:0] lim);
        bcd_inc_t r;
        r.carry = 1'b0;
        r.val   = v;
        if (v >= lim) begin
            r.carry = 1'b1;
            r.val   = 8'h00;
        end else if (v[3:0] >= 4'd9) begin
            r.val = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r.val = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser plus sample-enabled debounce; emits a one-cycle pulse on each accepted press.
module key_debounce #(
    parameter int DEB_SAMPLES = 3
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic samp_en_i,
    input  logic key_i,
    output logic press_o
);

    localparam int CW = (DEB_SAMPLES > 1) ? $clog2(DEB_SAMPLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_SAMPLES - 1);

    logic [1:0]    sync_q;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_q, press_d;

    // A level is accepted only after DEB_SAMPLES consecutive disagreeing samples.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        press_d  = 1'b0;
        if (samp_en_i) begin
            if (sync_q[1] == stable_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                stable_d = ~stable_q;
                cnt_d    = '0;
                press_d  = ~stable_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q   <= 2'b00;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            press_q  <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], key_i};
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            press_q  <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: key debounce, centisecond timebase, BCD mm:ss.cc cascade and run/pause/clear FSM.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV      = 500000,
    parameter int SAMPLE_DIV    = 500000,
    parameter int DEB_SAMPLES   = 3,
    parameter int BLINK_SAMPLES = 25
) (
    input  logic       clk_50mhz,
    input  logic       rst,
    input  logic       key_ss,
    input  logic       key_clr,
    output logic [7:0] cs_bcd,
    output logic [7:0] sec_bcd,
    output logic [7:0] min_bcd,
    output logic       running,
    output logic       overflow,
    output logic       blink
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int BW = (BLINK_SAMPLES > 1) ? $clog2(BLINK_SAMPLES) : 1;
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SAMP_LAST  = SW'(SAMPLE_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_SAMPLES - 1);

    logic [SW-1:0] samp_cnt_q, samp_cnt_d;
    logic          samp_en;
    logic          ss_p, clr_p;

    sw_state_e     state_q;
    logic [TW-1:0] tb_cnt_q, tb_cnt_d;
    logic [BW-1:0] blink_cnt_q;
    logic [7:0]    cs_q, sec_q, min_q;
    logic          running_q, overflow_q, blink_q;

    logic          tick, at_max;
    bcd_inc_t      cs_inc, sec_inc, min_inc;

    assign samp_en    = (samp_cnt_q == SAMP_LAST);
    assign samp_cnt_d = samp_en ? '0 : samp_cnt_q + 1'b1;

    always_ff @(posedge clk_50mhz) begin
        if (rst) begin
            samp_cnt_q <= '0;
        end else begin
            samp_cnt_q <= samp_cnt_d;
        end
    end

    key_debounce #(.DEB_SAMPLES(DEB_SAMPLES)) u_deb_ss (
        .clk_i     (clk_50mhz),
        .rst_i     (rst),
        .samp_en_i (samp_en),
        .key_i     (key_ss),
        .press_o   (ss_p)
    );

    key_debounce #(.DEB_SAMPLES(DEB_SAMPLES)) u_deb_clr (
        .clk_i     (clk_50mhz),
        .rst_i     (rst),
        .samp_en_i (samp_en),
        .key_i     (key_clr),
        .press_o   (clr_p)
    );

    always_comb begin
        cs_inc  = bcd_inc(cs_q, CS_MAX);
        sec_inc = bcd_inc(sec_q, SEC_MAX);
        min_inc = bcd_inc(min_q, MIN_MAX);
    end

    // at_max: every digit pair sits at its limit, i.e. 59:59.99.
    assign at_max   = cs_inc.carry & sec_inc.carry & min_inc.carry;
    assign tick     = (state_q == RUN) && (tb_cnt_q == TICK_LAST);
    assign tb_cnt_d = (tb_cnt_q == TICK_LAST) ? '0 : tb_cnt_q + 1'b1;

    always_ff @(posedge clk_50mhz) begin
        if (rst) begin
            state_q     <= IDLE;
            tb_cnt_q    <= '0;
            blink_cnt_q <= '0;
            cs_q        <= 8'h00;
            sec_q       <= 8'h00;
            min_q       <= 8'h00;
            running_q   <= 1'b0;
            overflow_q  <= 1'b0;
            blink_q     <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ss_p) begin
                        state_q   <= RUN;
                        running_q <= 1'b1;
                        tb_cnt_q  <= '0;
                    end
                end
                RUN: begin
                    tb_cnt_q <= tb_cnt_d;
                    if (tick && at_max) begin
                        state_q    <= FULL;
                        running_q  <= 1'b0;
                        overflow_q <= 1'b1;
                        blink_q    <= 1'b0;
                    end else begin
                        // A tick coinciding with ss_p is still counted before pausing.
                        if (tick) begin
                            cs_q <= cs_inc.val;
                            if (cs_inc.carry) begin
                                sec_q <= sec_inc.val;
                            end
                            if (cs_inc.carry && sec_inc.carry) begin
                                min_q <= min_inc.val;
                            end
                        end
                        if (ss_p) begin
                            state_q     <= PAUSE;
                            running_q   <= 1'b0;
                            blink_q     <= 1'b1;
                            blink_cnt_q <= '0;
                        end
                    end
                end
                PAUSE: begin
                    if (clr_p) begin
                        state_q <= IDLE;
                        cs_q    <= 8'h00;
                        sec_q   <= 8'h00;
                        min_q   <= 8'h00;
                        blink_q <= 1'b1;
                    end else if (ss_p) begin
                        state_q   <= RUN;
                        running_q <= 1'b1;
                        blink_q   <= 1'b1;
                    end else if (samp_en) begin
                        if (blink_cnt_q == BLINK_LAST) begin
                            blink_cnt_q <= '0;
                            blink_q     <= ~blink_q;
                        end else begin
                            blink_cnt_q <= blink_cnt_q + 1'b1;
                        end
                    end
                end
                FULL: begin
                    if (clr_p) begin
                        state_q    <= IDLE;
                        cs_q       <= 8'h00;
                        sec_q      <= 8'h00;
                        min_q      <= 8'h00;
                        overflow_q <= 1'b0;
                        blink_q    <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cs_bcd   = cs_q;
    assign sec_bcd  = sec_q;
    assign min_bcd  = min_q;
    assign running  = running_q;
    assign overflow = overflow_q;
    assign blink    = blink_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with short time bases.
module tb_stopwatch_ctrl;
    import stopwatch_pkg::*;

    localparam int TICK_DIV      = 10;
    localparam int SAMPLE_DIV    = 4;
    localparam int DEB_SAMPLES   = 3;
    localparam int BLINK_SAMPLES = 2;

    logic       clk_50mhz = 1'b0;
    logic       rst       = 1'b1;
    logic       key_ss    = 1'b0;
    logic       key_clr   = 1'b0;
    logic [7:0] cs_bcd, sec_bcd, min_bcd;
    logic       running, overflow, blink;

    int n_chk     = 0;
    int n_bad     = 0;
    int ss_pulses = 0;

    stopwatch_ctrl #(
        .TICK_DIV      (TICK_DIV),
        .SAMPLE_DIV    (SAMPLE_DIV),
        .DEB_SAMPLES   (DEB_SAMPLES),
        .BLINK_SAMPLES (BLINK_SAMPLES)
    ) dut (
        .clk_50mhz (clk_50mhz),
        .rst       (rst),
        .key_ss    (key_ss),
        .key_clr   (key_clr),
        .cs_bcd    (cs_bcd),
        .sec_bcd   (sec_bcd),
        .min_bcd   (min_bcd),
        .running   (running),
        .overflow  (overflow),
        .blink     (blink)
    );

    always #5 clk_50mhz = ~clk_50mhz;

    always @(negedge clk_50mhz) begin
        if (dut.ss_p) ss_pulses++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_50mhz);
    endtask

    task automatic press_key(input logic ss, input logic clr, input int hold);
        key_ss  = ss;
        key_clr = clr;
        cyc(hold);
        key_ss  = 1'b0;
        key_clr = 1'b0;
        cyc(20);
    endtask

    task automatic wait_running(input logic lvl, input int max);
        for (int i = 0; i < max; i++) begin
            @(negedge clk_50mhz);
            if (running === lvl) break;
        end
        chk("wait_running", running, lvl);
    endtask

    int p, ph, k, t1, t2, p0;
    logic prev_blink;

    initial begin
        // Reset and idle
        cyc(5);
        rst = 1'b0;
        cyc(200);
        chk("rst_cs", cs_bcd, 8'h00);
        chk("rst_sec", sec_bcd, 8'h00);
        chk("rst_min", min_bcd, 8'h00);
        chk("rst_running", running, 1'b0);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_blink", blink, 1'b1);
        chk("rst_state", dut.state_q, IDLE);

        // Clean press, then 1.00 s and 1.50 s after running rises
        key_ss = 1'b1;
        wait_running(1'b1, 40);
        for (int i = 1; i <= 1500; i++) begin
            @(posedge clk_50mhz);
            #1;
            if (i == 25) key_ss = 1'b0;
            if (i == 1000) begin
                chk("run1000_cs", cs_bcd, 8'h00);
                chk("run1000_sec", sec_bcd, 8'h01);
                chk("run1000_min", min_bcd, 8'h00);
                chk("one_ss_pulse", ss_pulses, 1);
                chk("run1000_running", running, 1'b1);
            end
            if (i == 1500) begin
                chk("run1500_cs", cs_bcd, 8'h50);
                chk("run1500_sec", sec_bcd, 8'h01);
            end
        end

        // Pause, then clear from PAUSE
        press_key(1'b1, 1'b0, 20);
        chk("pause_state", dut.state_q, PAUSE);
        press_key(1'b0, 1'b1, 20);
        chk("clr_state", dut.state_q, IDLE);
        chk("clr_cs", cs_bcd, 8'h00);
        chk("clr_sec", sec_bcd, 8'h00);

        // Fresh run, pause near 250 cycles
        key_ss = 1'b1;
        wait_running(1'b1, 40);
        p = 0;
        for (int i = 1; i <= 300; i++) begin
            @(posedge clk_50mhz);
            #1;
            if (running === 1'b0) begin
                p = i;
                break;
            end
            if (i == 20) key_ss = 1'b0;
            if (i == 238) key_ss = 1'b1;
        end
        chk("pause_seen", running, 1'b0);
        ph = p % 10;
        chk("pause_cs", cs_bcd, 8'h25);
        chk("pause_sec", sec_bcd, 8'h00);
        chk("pause_blink_entry", blink, 1'b1);

        key_ss = 1'b0;
        prev_blink = blink;
        t1 = -1;
        t2 = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk_50mhz);
            #1;
            if (blink !== prev_blink) begin
                if (t1 < 0) t1 = i;
                else if (t2 < 0) t2 = i;
            end
            prev_blink = blink;
        end
        chk("blink_period", t2 - t1, 8);
        chk("pause_frozen_cs", cs_bcd, 8'h25);

        // Resume: next increment lands at the preserved phase
        key_ss = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk_50mhz);
            #1;
            if (running === 1'b1) break;
        end
        chk("resume_running", running, 1'b1);
        k = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk_50mhz);
            #1;
            if (cs_bcd !== 8'h25) begin
                k = i;
                break;
            end
        end
        chk("resume_phase", k, 10 - ph);
        chk("resume_cs", cs_bcd, 8'h26);
        key_ss = 1'b0;
        cyc(20);

        // Overflow from 59:59.98
        @(negedge clk_50mhz);
        force dut.cs_q  = 8'h98;
        force dut.sec_q = 8'h59;
        force dut.min_q = 8'h59;
        #1;
        release dut.cs_q;
        release dut.sec_q;
        release dut.min_q;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk_50mhz);
            #1;
            if (cs_bcd === 8'h99) break;
        end
        chk("max_cs", cs_bcd, 8'h99);
        chk("max_sec", sec_bcd, 8'h59);
        chk("max_min", min_bcd, 8'h59);
        chk("max_overflow", overflow, 1'b0);
        k = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk_50mhz);
            #1;
            if (overflow === 1'b1) begin
                k = i;
                break;
            end
        end
        chk("full_latency", k, TICK_DIV);
        chk("full_overflow", overflow, 1'b1);
        chk("full_blink", blink, 1'b0);
        chk("full_running", running, 1'b0);
        chk("full_hold_cs", cs_bcd, 8'h99);
        chk("full_hold_min", min_bcd, 8'h59);
        press_key(1'b1, 1'b0, 30);
        chk("full_ss_ignored", overflow, 1'b1);
        chk("full_ss_cs", cs_bcd, 8'h99);
        press_key(1'b0, 1'b1, 30);
        chk("full_clr_overflow", overflow, 1'b0);
        chk("full_clr_state", dut.state_q, IDLE);
        chk("full_clr_cs", cs_bcd, 8'h00);
        chk("full_clr_sec", sec_bcd, 8'h00);
        chk("full_clr_min", min_bcd, 8'h00);
        chk("full_clr_blink", blink, 1'b1);

        // Both keys in PAUSE: clear wins
        press_key(1'b1, 1'b0, 20);
        press_key(1'b1, 1'b0, 20);
        chk("both_pre_state", dut.state_q, PAUSE);
        press_key(1'b1, 1'b1, 20);
        chk("both_pause_state", dut.state_q, IDLE);
        chk("both_pause_cs", cs_bcd, 8'h00);

        // Both keys in RUN: start/stop wins
        press_key(1'b1, 1'b0, 20);
        press_key(1'b1, 1'b1, 20);
        chk("both_run_state", dut.state_q, PAUSE);
        chk("both_run_running", running, 1'b0);
        chk("both_run_cs_kept", cs_bcd != 8'h00, 1'b1);

        // Reset mid-RUN with a clear-key debounce in flight
        press_key(1'b1, 1'b0, 20);
        chk("pre_rst_running", running, 1'b1);
        key_clr = 1'b1;
        cyc(9);
        rst = 1'b1;
        @(negedge clk_50mhz);
        rst = 1'b0;
        chk("mrst_state", dut.state_q, IDLE);
        chk("mrst_cs", cs_bcd, 8'h00);
        chk("mrst_sec", sec_bcd, 8'h00);
        chk("mrst_running", running, 1'b0);
        chk("mrst_overflow", overflow, 1'b0);
        chk("mrst_blink", blink, 1'b1);
        chk("mrst_deb_cnt", dut.u_deb_clr.cnt_q, 0);
        chk("mrst_deb_sync", dut.u_deb_clr.sync_q, 2'b00);
        key_clr = 1'b0;
        cyc(20);

        // Bouncing start key then stable high
        p0 = ss_pulses;
        for (int i = 0; i < 10; i++) begin
            key_ss = ~key_ss;
            cyc(3);
        end
        key_ss = 1'b1;
        cyc(40);
        chk("bounce_pulses", ss_pulses - p0, 1);
        chk("bounce_state", dut.state_q, RUN);
        chk("bounce_running", running, 1'b1);
        key_ss = 1'b0;
        cyc(20);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Stopwatch controller sitting behind the board's 50 MHz clock, displaying minutes, seconds and centiseconds as BCD.
- Generates all time bases internally as single-cycle clock enables. No derived clocks; every flop runs on clk_50mhz.
- Debounces two push keys and sequences run, pause, clear and overflow through a 4-state FSM.
- Feeds the existing 7-segment scan/decoder logic.

Parameters:
- TICK_DIV, 500000: clk_50mhz cycles per centisecond tick (100 Hz timebase).
- SAMPLE_DIV, 500000: cycles between key samples (100 Hz sample enable).
- DEB_SAMPLES, 3: consecutive equal samples needed to accept a key level.
- BLINK_SAMPLES, 25: sample enables per blink toggle (2 Hz blink).

Ports:
- clk_50mhz, in, 1: system clock, all logic on its rising edge.
- rst, in, 1: synchronous reset, active-high.
- key_ss, in, 1: raw start/stop key, active-high, asynchronous to clock.
- key_clr, in, 1: raw clear key, active-high, asynchronous to clock.
- cs_bcd, out, 8: centiseconds, two BCD digits, 00-99.
- sec_bcd, out, 8: seconds, two BCD digits, 00-59.
- min_bcd, out, 8: minutes, two BCD digits, 00-59.
- running, out, 1: high only in state RUN.
- overflow, out, 1: high only in state FULL.
- blink, out, 1: display-enable hint for the scan logic.

Behaviour:
- Clocking and reset: one clock, clk_50mhz. Reset is synchronous and active-high on rst.
- Reset values: state=IDLE, all BCD outputs 00, running=0, overflow=0, blink=1, all counters 0, sync/debounce registers 0.
- Key synchroniser: each key passes through a 2-flop synchroniser.
- Sample enable: a free-running counter 0..SAMPLE_DIV-1 produces samp_en when it equals SAMPLE_DIV-1.
- Debounce:
  - On samp_en, the synced level is compared with the stable level. A match clears the agreement count; a mismatch increments it.
  - When the count reaches DEB_SAMPLES-1 and a mismatch is sampled, the stable level flips and the count clears.
  - A 0->1 stable transition emits a 1-cycle press pulse (ss_p or clr_p).
  - Holding a key yields exactly one pulse. Release produces no pulse.
- Timebase:
  - tb_cnt counts 0..TICK_DIV-1 only in RUN and holds its value in PAUSE, so the fractional centisecond is preserved.
  - tb_cnt clears on entry to RUN from IDLE.
  - tick is asserted when tb_cnt==TICK_DIV-1 and state==RUN.
- BCD counting on tick: the count increments as a 6-digit cascade.
  - cs units 9->0 with carry; cs 99->00 carries into sec.
  - sec units 9->0; sec 59->00 carries into min; min 59->00.
  - No digit ever leaves the BCD range.
- FSM, evaluated each cycle on the press pulses:
  - IDLE: ss_p -> RUN.
  - RUN: ss_p -> PAUSE. clr_p is ignored. A tick at 59:59.99 -> FULL; digits hold at 59:59.99 and do not wrap.
  - PAUSE: clr_p -> IDLE with all digits cleared the same cycle. Otherwise ss_p -> RUN, resuming without clearing tb_cnt.
  - FULL: clr_p -> IDLE with digits cleared. ss_p is ignored.
- Simultaneous events:
  - clr_p and ss_p in the same cycle: clr_p wins wherever clear is legal (PAUSE, FULL). In RUN, ss_p is taken.
  - tick and ss_p in the same cycle in RUN: the increment is applied, then the FSM goes to PAUSE with the incremented value.
- Latency:
  - running/overflow are registered and change on the edge after the press pulse or final tick.
  - The first increment after IDLE->RUN occurs exactly TICK_DIV cycles after running rises.
- Blink:
  - 1 in IDLE and RUN.
  - In PAUSE, toggles every BLINK_SAMPLES samp_en. The blink counter clears and blink is set to 1 on PAUSE entry.
  - 0 in FULL.
- Mid-operation reset: rst asserted in any state returns all reset values on the next edge, including any in-flight debounce count.

Decomposition:
- Package stopwatch_pkg holds:
  - the state encoding (IDLE, RUN, PAUSE, FULL, 2 bits);
  - BCD limit constants (CS_MAX=8'h99, SEC_MAX=8'h59, MIN_MAX=8'h59);
  - the BCD increment function.
- One sub-module, key_debounce (synchroniser, sample-enabled debounce, press pulse), instantiated twice. samp_en is shared from the top.

Test Plan:
- Simulation parameters: TICK_DIV=10, SAMPLE_DIV=4, DEB_SAMPLES=3, BLINK_SAMPLES=2.
- Reset then idle 200 cycles -> digits 00:00.00, running=0, overflow=0, blink=1.
- Clean key_ss press held 40 cycles -> exactly one ss_p, running=1. After a further 1000 cycles cs_bcd=8'h00, sec_bcd=8'h01; after 1500 cycles cs_bcd=8'h50.
- key_ss bouncing 0/1 every 3 cycles for 30 cycles, then stable high -> a single transition to RUN, no PAUSE glitch.
- RUN for 250 cycles, press ss -> PAUSE with digits frozen (00:00.25), blink toggles every 8 cycles. Press ss again -> the next increment arrives at the preserved tb_cnt phase.
- Force digits to 59:59.98 in RUN, then 2 ticks -> 59:59.99 then FULL, overflow=1, blink=0. ss ignored. clr -> IDLE, 00:00.00.
- In PAUSE, assert both keys together -> IDLE and cleared. In RUN, both keys together -> PAUSE. rst pulse mid-RUN -> all reset values next edge.
